// File: rtl/halfword_ram.sv
// rtl/halfword_ram.sv - halfword-wide single-port RAM with byte enables; optional post-reset clear under MEM_CLEAR_EN
module halfword_ram #(
    parameter int MEM_DEPTH = 2**12,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_en,
    input  logic                  i_rd_en,
    input  logic [0:1]            i_wr_en,
    input  logic [0:1][7:0]       i_di,
    output logic [0:1][7:0]       o_do,
    output logic                  o_rd_valid,
    output logic                  o_ready,
    output logic                  o_err
);
    localparam int IDX_W = ADDR_WIDTH - 1;

    logic [0:1][7:0]  mem [MEM_DEPTH];
    logic [IDX_W-1:0] idx;
    logic             misaligned;
    logic             accept;
    logic             clearing;
    logic [IDX_W-1:0] clr_idx;
    logic [0:1]       mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [0:1][7:0]  mem_wdata;

    assign idx        = i_addr[ADDR_WIDTH-1:1];
    assign misaligned = i_addr[0];
    assign accept     = o_ready & i_en & (i_rd_en | (|i_wr_en));

`ifdef MEM_CLEAR_EN
    typedef enum logic {INIT, IDLE} state_t;
    state_t           state;
    logic [IDX_W-1:0] clr_cnt;

    // o_ready rises together with the INIT->IDLE transition so it stays registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
            o_ready <= 1'b0;
        end else if (state == INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == IDX_W'(MEM_DEPTH - 1)) begin
                state   <= IDLE;
                o_ready <= 1'b1;
            end
        end
    end

    assign clearing = (state == INIT);
    assign clr_idx  = clr_cnt;
`else
    assign o_ready  = 1'b1;
    assign clearing = 1'b0;
    assign clr_idx  = '0;
`endif

    always_comb begin
        mem_we    = '0;
        mem_widx  = idx;
        mem_wdata = i_di;
        if (!rst) begin
            if (clearing) begin
                mem_we    = '1;
                mem_widx  = clr_idx;
                mem_wdata = '0;
            end else if (accept && !misaligned) begin
                mem_we = i_wr_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_we[k]) mem[mem_widx][k] <= mem_wdata[k];
        end
    end

    // read samples the array before this edge's write lands: read-first
    always_ff @(posedge clk) begin
        if (rst) begin
            o_do       <= '0;
            o_rd_valid <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_rd_valid <= accept & i_rd_en;
            o_err      <= accept & misaligned;
            if (accept && i_rd_en) o_do <= misaligned ? '0 : mem[idx];
        end
    end
endmodule

// File: tb/tb_halfword_ram.sv
// tb/tb_halfword_ram.sv - scoreboard bench for halfword_ram (MEM_DEPTH=16, either MEM_CLEAR_EN build)
module tb_halfword_ram;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  i_addr = '0;
    logic           i_en = 1'b0;
    logic           i_rd_en = 1'b0;
    logic [0:1]     i_wr_en = '0;
    logic [0:1][7:0] i_di = '0;
    logic [0:1][7:0] o_do;
    logic           o_rd_valid, o_ready, o_err;

    halfword_ram #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_en(i_en), .i_rd_en(i_rd_en),
        .i_wr_en(i_wr_en), .i_di(i_di), .o_do(o_do), .o_rd_valid(o_rd_valid),
        .o_ready(o_ready), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        valid;
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [DEPTH];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_rd_valid || o_err) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, o_rd_valid, o_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("rd_valid", {31'd0, o_rd_valid}, {31'd0, e.valid});
                check("err", {31'd0, o_err}, {31'd0, e.err});
                if (e.valid) check("rd_data", {16'd0, o_do}, {16'd0, e.data});
            end
        end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
            e = sb.pop_front();
            check("missing_pulse", {30'd0, o_rd_valid, o_err}, {30'd0, e.valid, e.err});
        end
    end

    // bench only issues through this task while the DUT is known to be ready
    task automatic issue(input logic [AW-1:0] addr, input logic en, input logic rd,
                         input logic [1:0] we, input logic [15:0] di);
        exp_t e;
        @(posedge clk); #1;
        i_addr = addr; i_en = en; i_rd_en = rd; i_wr_en = we; i_di = di;
        if (en && (rd || we != 2'b00)) begin
            e.cyc   = cyc + 1;
            e.valid = rd;
            e.err   = addr[0];
            e.data  = addr[0] ? 16'h0000 : model[addr[AW-1:1]];
            sb.push_back(e);
            if (!addr[0]) begin
                if (we[1]) model[addr[AW-1:1]][15:8] = di[15:8];
                if (we[0]) model[addr[AW-1:1]][7:0]  = di[7:0];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            i_en = 1'b0; i_rd_en = 1'b0; i_wr_en = '0;
        end
    endtask

`ifdef MEM_CLEAR_EN
    task automatic wait_clear();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("ready_init", {31'd0, o_ready}, 32'd0);
            if (i == DEPTH - 1) begin
                i_en = 1'b0; i_rd_en = 1'b0; i_wr_en = '0;
            end
        end
        @(negedge clk);
        check("ready_up", {31'd0, o_ready}, 32'd1);
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_do", {16'd0, o_do}, 32'd0);
        check("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
`ifdef MEM_CLEAR_EN
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        wait_clear();
        issue(5'h1E, 1, 1, 2'b00, 16'h0);
        idle(2);
`else
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk); #1; rst = 1'b0;
`endif
        // byte enables
        issue(5'h04, 1, 0, 2'b11, 16'hA55A);
        issue(5'h04, 1, 0, 2'b01, 16'h00FF);
        issue(5'h04, 1, 1, 2'b00, 16'h0);
        idle(2);
        // read-first
        issue(5'h08, 1, 0, 2'b11, 16'h1234);
        issue(5'h08, 1, 1, 2'b11, 16'hABCD);
        issue(5'h08, 1, 1, 2'b00, 16'h0);
        idle(2);
        // misaligned write, read and read+write
        issue(5'h05, 1, 0, 2'b11, 16'hFFFF);
        issue(5'h04, 1, 1, 2'b00, 16'h0);
        issue(5'h05, 1, 1, 2'b00, 16'h0);
        issue(5'h05, 1, 1, 2'b11, 16'h9999);
        issue(5'h04, 1, 1, 2'b00, 16'h0);
        idle(2);
        // back-to-back reads
        issue(5'h00, 1, 0, 2'b11, 16'h1111);
        issue(5'h02, 1, 0, 2'b11, 16'h2222);
        issue(5'h00, 1, 1, 2'b00, 16'h0);
        issue(5'h02, 1, 1, 2'b00, 16'h0);
        issue(5'h04, 1, 1, 2'b00, 16'h0);
        idle(2);
        // ignored requests: en low, or en with no rd/wr
        issue(5'h00, 0, 1, 2'b11, 16'hDEAD);
        issue(5'h02, 1, 0, 2'b00, 16'hBEEF);
        issue(5'h00, 1, 1, 2'b00, 16'h0);
        issue(5'h02, 1, 1, 2'b00, 16'h0);
        idle(2);
        // random traffic over a fully written array
        for (int i = 0; i < DEPTH; i++) issue(AW'(i * 2), 1, 0, 2'b11, 16'($urandom));
        for (int i = 0; i < 60; i++)
            issue(AW'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0),
                  1'($urandom), 2'($urandom), 16'($urandom));
        idle(3);
`ifdef MEM_CLEAR_EN
        // reset partway through the clear, with requests during rst and INIT
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        repeat (7) @(posedge clk);
        #1; rst = 1'b1; i_addr = 5'h04; i_en = 1'b1; i_rd_en = 1'b1; i_wr_en = 2'b11; i_di = 16'h7777;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst_do", {16'd0, o_do}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        wait_clear();
        issue(5'h04, 1, 1, 2'b00, 16'h0);
        issue(5'h1E, 1, 1, 2'b00, 16'h0);
        idle(2);
`else
        // reset with a concurrent write: dropped, array preserved
        @(posedge clk); #1;
        rst = 1'b1; i_addr = 5'h04; i_en = 1'b1; i_rd_en = 1'b1; i_wr_en = 2'b11; i_di = 16'h7777;
        @(posedge clk); #1; rst = 1'b0; i_en = 1'b0; i_rd_en = 1'b0; i_wr_en = '0;
        @(negedge clk);
        check("rst2_ready", {31'd0, o_ready}, 32'd1);
        check("rst2_do", {16'd0, o_do}, 32'd0);
        issue(5'h04, 1, 1, 2'b00, 16'h0);
        issue(5'h08, 1, 1, 2'b00, 16'h0);
        idle(2);
`endif
        idle(3);
        check("sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
